mem_bus_arbiter: RTL and testbench
==================================

Name: mem_bus_arbiter

Overview:
- Shares one SRAM-like memory bus between the fetch-stage instruction port and the mem-stage data port of the 5-stage pipeline.
- Sequences each access through an address phase and a data phase.
- Returns read data to the requesting stage.
- Drives a pipeline-wide stall into the hazard unit until every pending access of the current cycle has completed.

Parameters:
- AW, 32, address width
- DW, 32, data width
- TIMEOUT_CYC, 255, data-phase cycle limit; used only with the optional feature

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-low
- inst_req  in  1  fetch stage wants instruction word (level)
- inst_addr  in  AW  fetch address (pc_F)
- inst_rdata  out  DW  fetched instruction, held until next inst completion
- data_req  in  1  mem stage wants load/store (level)
- data_wr  in  1  1 = store
- data_size  in  2  0 byte, 1 half, 2 word
- data_addr  in  AW  alu_out_M
- data_wdata  in  DW  write_data_M
- data_rdata  out  DW  load word, held until next data completion
- ext_stall  in  1  pipeline held by another source (e.g. divider busy)
- cpu_stall  out  1  to hazard unit; freezes F/D/E/M
- bus_req  out  1  bus request
- bus_wr  out  1  bus write
- bus_size  out  2  bus size
- bus_addr  out  AW  bus address
- bus_wdata  out  DW  bus write data
- bus_addr_ok  in  1  slave accepted address
- bus_data_ok  in  1  slave returns data or write acknowledge
- bus_rdata  in  DW  slave read data

Behaviour:
- FSM states: IDLE, I_ADDR, I_DATA, D_ADDR, D_DATA.
- Pending definitions:
  - inst_pend = inst_req & ~inst_done
  - data_pend = data_req & ~data_done
  - inst_done and data_done are registered flags.
- IDLE:
  - data_pend -> D_ADDR (data has priority).
  - Otherwise inst_pend -> I_ADDR.
  - Otherwise stay in IDLE.
- I_ADDR / D_ADDR:
  - bus_req=1; bus fields driven from the latched request.
  - On bus_addr_ok -> I_DATA / D_DATA; bus_req drops the same edge.
- I_DATA:
  - On bus_data_ok: inst_rdata<=bus_rdata, inst_done<=1.
  - Next state: D_ADDR if data_pend, else IDLE.
- D_DATA:
  - On bus_data_ok: data_rdata<=bus_rdata (reads only; stores leave data_rdata unchanged), data_done<=1.
  - Next state: I_ADDR if inst_pend, else IDLE.
- bus_addr_ok and bus_data_ok asserted in the same cycle as bus_req: address phase completes; data_ok is ignored. At most one outstanding transaction.
- Request latching:
  - Request fields (wr, size, addr, wdata) are latched on entry to the *_ADDR state.
  - They stay stable until the data phase ends, even if inputs change.
- bus_req is 0 in IDLE and in *_DATA states. Bus outputs are registered.
- cpu_stall is combinational: (inst_pend | data_pend) | (state != IDLE).
- Clearing done flags:
  - Both flags clear on any edge where cpu_stall=0 and ext_stall=0 (pipeline advances).
  - While ext_stall=1 the flags hold, so a completed store is never reissued.
- Minimum latency, addr_ok and data_ok each 1 cycle: one access = 2 cycles of stall. Concurrent inst+data = 4 cycles.
- Reset:
  - state=IDLE, done flags=0, bus_req=0, bus_wr=0, bus_size=0, bus_addr=0, bus_wdata=0, inst_rdata=0, data_rdata=0.
  - Reset mid-transaction abandons it without waiting for data_ok. A late data_ok arriving in IDLE is ignored.
- data_req and inst_req are both zero in IDLE: no bus activity; cpu_stall=0.

Optional Feature:
- Macro: MEM_BUS_ARBITER_TIMEOUT_EN.
- Defined:
  - An 8-bit-minimum counter (width $clog2(TIMEOUT_CYC+1)) runs in *_DATA states.
  - Reaching TIMEOUT_CYC forces completion: rdata<=32'hDEAD_BEEF, done flag set, next state per normal rules.
  - Added output bus_err (1 bit) pulses high for one cycle and is sticky-ORed into bus_err_sticky (out, cleared only by reset).
- Undefined: no counter; bus_err and bus_err_sticky ports absent; the FSM waits indefinitely.

Decomposition:
- Shared package holds:
  - state encoding enum (IDLE=0, I_ADDR=1, I_DATA=2, D_ADDR=3, D_DATA=4, 3 bits)
  - size constants SZ_BYTE/SZ_HALF/SZ_WORD
  - timeout fill constant 32'hDEAD_BEEF
- One natural sub-module: bus_req_latch, which holds the registered request fields with a load enable and feeds the bus outputs.

Test Plan:
- inst_req=1, addr=0xBFC00000, slave addr_ok/data_ok after 1 cycle, rdata=0x24080001 -> cpu_stall high 2 cycles, inst_rdata=0x24080001, bus_wr=0.
- inst_req and data_req(store, size=2, addr=0x80001000, wdata=0x12345678) together -> data transaction first (bus_wr=1, wdata=0x12345678), then instruction; cpu_stall high 4 cycles.
- Store completes while ext_stall=1 for 5 cycles -> exactly one bus_req write phase; data_done held; flags clear on first edge with ext_stall=0.
- Slave delays addr_ok 3 cycles, data_ok 4 cycles -> bus_addr/bus_wdata stable throughout although data_addr input changes to 0x0 mid-phase; stall 7+ cycles.
- rst=0 asserted during D_DATA, then data_ok pulses in IDLE -> state IDLE, data_rdata=0, no done flag set.
- Timeout macro defined, TIMEOUT_CYC=8, slave never gives data_ok -> after 8 data-phase cycles data_rdata=0xDEADBEEF, bus_err one-cycle pulse, bus_err_sticky=1.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
`default_nettype none
// =============================================================================
// mem_bus_arbiter_pkg : state encoding and shared constants for the arbiter.
// Revision: 1.0
// =============================================================================
package mem_bus_arbiter_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_I_ADDR = 3'd1;
    localparam logic [2:0] ST_I_DATA = 3'd2;
    localparam logic [2:0] ST_D_ADDR = 3'd3;
    localparam logic [2:0] ST_D_DATA = 3'd4;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    localparam logic [31:0] TIMEOUT_FILL = 32'hDEAD_BEEF;

endpackage
`default_nettype wire

// File: rtl/mem_bus_arbiter_bus_req_latch.sv
`default_nettype none
// =============================================================================
// mem_bus_arbiter_bus_req_latch : registered bus request fields, loaded on
// entry to an address phase and held through the data phase.
// Revision: 1.0
// =============================================================================
module mem_bus_arbiter_bus_req_latch
    import mem_bus_arbiter_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load_i,
    input  logic          wr_i,
    input  logic [1:0]    size_i,
    input  logic [AW-1:0] addr_i,
    input  logic [DW-1:0] wdata_i,
    output logic          wr_o,
    output logic [1:0]    size_o,
    output logic [AW-1:0] addr_o,
    output logic [DW-1:0] wdata_o
);

    logic          wr_q;
    logic [1:0]    size_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_q    <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (load_i) begin
            wr_q    <= wr_i;
            size_q  <= size_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
        end
    end

    assign wr_o    = wr_q;
    assign size_o  = size_q;
    assign addr_o  = addr_q;
    assign wdata_o = wdata_q;

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// =============================================================================
// mem_bus_arbiter : shares one SRAM-like bus between fetch and mem stages,
// data priority, stalls the pipeline until all pending accesses complete.
// Optional macro MEM_BUS_ARBITER_TIMEOUT_EN adds a data-phase timeout.
// Revision: 1.0
// =============================================================================
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inst_req,
    input  logic [AW-1:0] inst_addr,
    output logic [DW-1:0] inst_rdata,
    input  logic          data_req,
    input  logic          data_wr,
    input  logic [1:0]    data_size,
    input  logic [AW-1:0] data_addr,
    input  logic [DW-1:0] data_wdata,
    output logic [DW-1:0] data_rdata,
    input  logic          ext_stall,
    output logic          cpu_stall,
    output logic          bus_req,
    output logic          bus_wr,
    output logic [1:0]    bus_size,
    output logic [AW-1:0] bus_addr,
    output logic [DW-1:0] bus_wdata,
    input  logic          bus_addr_ok,
    input  logic          bus_data_ok,
    input  logic [DW-1:0] bus_rdata
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    ,
    output logic          bus_err,
    output logic          bus_err_sticky
`endif
);

    localparam logic [DW-1:0] C_FILL = DW'(TIMEOUT_FILL);

    logic [2:0]    state_q, state_d;
    logic          bus_req_q, bus_req_d;
    logic          inst_done_q, inst_done_d;
    logic          data_done_q, data_done_d;
    logic [DW-1:0] inst_rdata_q, inst_rdata_d;
    logic [DW-1:0] data_rdata_q, data_rdata_d;

    logic          w_inst_pend;
    logic          w_data_pend;
    logic          w_advance;
    logic          w_timeout;
    logic          w_fin;
    logic [DW-1:0] w_rsel;
    logic          w_load;
    logic          w_sel_inst;
    logic          w_ld_wr;
    logic [1:0]    w_ld_size;
    logic [AW-1:0] w_ld_addr;
    logic [DW-1:0] w_ld_wdata;

    assign w_inst_pend = inst_req & ~inst_done_q;
    assign w_data_pend = data_req & ~data_done_q;
    assign cpu_stall   = w_inst_pend | w_data_pend | (state_q != ST_IDLE);
    assign w_advance   = ~cpu_stall & ~ext_stall;

    assign w_fin  = bus_data_ok | w_timeout;
    assign w_rsel = w_timeout ? C_FILL : bus_rdata;

    // Instruction fetches are always word reads.
    assign w_ld_wr    = w_sel_inst ? 1'b0    : data_wr;
    assign w_ld_size  = w_sel_inst ? SZ_WORD : data_size;
    assign w_ld_addr  = w_sel_inst ? inst_addr : data_addr;
    assign w_ld_wdata = w_sel_inst ? '0      : data_wdata;

    always_comb begin
        state_d      = state_q;
        bus_req_d    = bus_req_q;
        inst_done_d  = inst_done_q;
        data_done_d  = data_done_q;
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        w_load       = 1'b0;
        w_sel_inst   = 1'b0;

        // Flags persist while the pipeline is held so a finished store is not reissued.
        if (w_advance) begin
            inst_done_d = 1'b0;
            data_done_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_data_pend) begin
                    state_d   = ST_D_ADDR;
                    w_load    = 1'b1;
                    bus_req_d = 1'b1;
                end else if (w_inst_pend) begin
                    state_d    = ST_I_ADDR;
                    w_load     = 1'b1;
                    w_sel_inst = 1'b1;
                    bus_req_d  = 1'b1;
                end
            end
            ST_I_ADDR: begin
                if (bus_addr_ok) begin
                    state_d   = ST_I_DATA;
                    bus_req_d = 1'b0;
                end
            end
            ST_D_ADDR: begin
                if (bus_addr_ok) begin
                    state_d   = ST_D_DATA;
                    bus_req_d = 1'b0;
                end
            end
            ST_I_DATA: begin
                if (w_fin) begin
                    inst_rdata_d = w_rsel;
                    inst_done_d  = 1'b1;
                    if (w_data_pend) begin
                        state_d   = ST_D_ADDR;
                        w_load    = 1'b1;
                        bus_req_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_D_DATA: begin
                if (w_fin) begin
                    if (!bus_wr || w_timeout) begin
                        data_rdata_d = w_rsel;
                    end
                    data_done_d = 1'b1;
                    if (w_inst_pend) begin
                        state_d    = ST_I_ADDR;
                        w_load     = 1'b1;
                        w_sel_inst = 1'b1;
                        bus_req_d  = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d   = ST_IDLE;
                bus_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            bus_req_q    <= 1'b0;
            inst_done_q  <= 1'b0;
            data_done_q  <= 1'b0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            bus_req_q    <= bus_req_d;
            inst_done_q  <= inst_done_d;
            data_done_q  <= data_done_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    mem_bus_arbiter_bus_req_latch #(
        .AW (AW),
        .DW (DW)
    ) u_req_latch (
        .clk     (clk),
        .rst     (rst),
        .load_i  (w_load),
        .wr_i    (w_ld_wr),
        .size_i  (w_ld_size),
        .addr_i  (w_ld_addr),
        .wdata_i (w_ld_wdata),
        .wr_o    (bus_wr),
        .size_o  (bus_size),
        .addr_o  (bus_addr),
        .wdata_o (bus_wdata)
    );

    assign bus_req    = bus_req_q;
    assign inst_rdata = inst_rdata_q;
    assign data_rdata = data_rdata_q;

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    localparam int TW = ($clog2(TIMEOUT_CYC + 1) < 8) ? 8 : $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] to_cnt_q;
    logic          bus_err_q;
    logic          bus_err_sticky_q;
    logic          w_in_data;

    assign w_in_data = (state_q == ST_I_DATA) || (state_q == ST_D_DATA);
    // A real data_ok on the final cycle wins over the forced completion.
    assign w_timeout = w_in_data && (to_cnt_q == TW'(TIMEOUT_CYC - 1)) && !bus_data_ok;

    always_ff @(posedge clk) begin
        if (!rst) begin
            to_cnt_q         <= '0;
            bus_err_q        <= 1'b0;
            bus_err_sticky_q <= 1'b0;
        end else begin
            to_cnt_q         <= w_in_data ? to_cnt_q + 1'b1 : '0;
            bus_err_q        <= w_timeout;
            bus_err_sticky_q <= bus_err_sticky_q | w_timeout;
        end
    end

    assign bus_err        = bus_err_q;
    assign bus_err_sticky = bus_err_sticky_q;
`else
    logic w_unused;

    assign w_timeout = 1'b0;
    assign w_unused  = (TIMEOUT_CYC != 0);
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
`default_nettype none
// =============================================================================
// tb_mem_bus_arbiter : directed self-checking bench with a simple bus slave.
// Revision: 1.0
// =============================================================================
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        ext_stall;
    logic        cpu_stall;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    logic        bus_err;
    logic        bus_err_sticky;
`endif

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .AW          (32),
        .DW          (32),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .inst_req    (inst_req),
        .inst_addr   (inst_addr),
        .inst_rdata  (inst_rdata),
        .data_req    (data_req),
        .data_wr     (data_wr),
        .data_size   (data_size),
        .data_addr   (data_addr),
        .data_wdata  (data_wdata),
        .data_rdata  (data_rdata),
        .ext_stall   (ext_stall),
        .cpu_stall   (cpu_stall),
        .bus_req     (bus_req),
        .bus_wr      (bus_wr),
        .bus_size    (bus_size),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_addr_ok (bus_addr_ok),
        .bus_data_ok (bus_data_ok),
        .bus_rdata   (bus_rdata)
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
        ,
        .bus_err        (bus_err),
        .bus_err_sticky (bus_err_sticky)
`endif
    );

    int          vectors = 0;
    int          miscompares = 0;
    int          nstall;
    int          nhs;
    int          s_addr_dly;
    int          s_data_dly;
    int          s_cnt;
    logic        s_phase;
    logic        s_mute;
    logic        s_late;
    logic [31:0] s_rdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance one clock and play the slave for the new cycle.
    task automatic step();
        @(posedge clk);
        #1;
        bus_addr_ok = 1'b0;
        bus_data_ok = 1'b0;
        if (s_late) begin
            bus_data_ok = 1'b1;
            bus_rdata   = 32'hAAAA_5555;
            s_late      = 1'b0;
        end else if (!s_phase) begin
            if (bus_req) begin
                if (s_cnt >= s_addr_dly) begin
                    bus_addr_ok = 1'b1;
                    s_phase     = 1'b1;
                    s_cnt       = 0;
                end else begin
                    s_cnt++;
                end
            end else begin
                s_cnt = 0;
            end
        end else if (!s_mute) begin
            if (s_cnt >= s_data_dly) begin
                bus_data_ok = 1'b1;
                bus_rdata   = s_rdata;
                s_phase     = 1'b0;
                s_cnt       = 0;
            end else begin
                s_cnt++;
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        if (cpu_stall) nstall++;
        if (bus_req && bus_addr_ok) nhs++;
    endtask

    task automatic cyc();
        step();
        sample();
    endtask

    initial begin
        rst = 1'b0; inst_req = 1'b0; inst_addr = '0; data_req = 1'b0; data_wr = 1'b0;
        data_size = 2'd0; data_addr = '0; data_wdata = '0; ext_stall = 1'b0;
        bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
        s_addr_dly = 0; s_data_dly = 0; s_cnt = 0; s_phase = 1'b0; s_mute = 1'b0;
        s_late = 1'b0; s_rdata = '0; nstall = 0; nhs = 0;

        // Reset values
        repeat (3) cyc();
        chk1("rst_stall", cpu_stall, 1'b0);
        chk1("rst_bus_req", bus_req, 1'b0);
        chk1("rst_bus_wr", bus_wr, 1'b0);
        chk("rst_bus_size", {30'd0, bus_size}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_inst_rdata", inst_rdata, 32'd0);
        chk("rst_data_rdata", data_rdata, 32'd0);
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
        chk1("rst_bus_err", bus_err, 1'b0);
        chk1("rst_bus_err_sticky", bus_err_sticky, 1'b0);
`endif
        step(); rst = 1'b1; sample();
        cyc(); cyc();
        chk1("idle_stall", cpu_stall, 1'b0);
        chk1("idle_bus_req", bus_req, 1'b0);

        // Single instruction fetch, zero-wait slave
        s_rdata = 32'h2408_0001;
        step(); inst_req = 1'b1; inst_addr = 32'hBFC0_0000; sample();
        chk1("t1_req_cycle_stall", cpu_stall, 1'b1);
        nstall = 0;
        cyc();
        chk1("t1_bus_req", bus_req, 1'b1);
        chk("t1_bus_addr", bus_addr, 32'hBFC0_0000);
        chk1("t1_bus_wr", bus_wr, 1'b0);
        chk("t1_bus_size", {30'd0, bus_size}, 32'd2);
        cyc(); cyc();
        chk("t1_stall_cycles", nstall, 32'd2);
        chk("t1_inst_rdata", inst_rdata, 32'h2408_0001);
        step(); inst_req = 1'b0; sample();

        // Simultaneous store and fetch: data first
        s_rdata = 32'h8C09_0000;
        step();
        inst_req = 1'b1; inst_addr = 32'hBFC0_0004;
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
        data_addr = 32'h8000_1000; data_wdata = 32'h1234_5678;
        sample();
        nstall = 0;
        cyc();
        chk1("t2_data_first_wr", bus_wr, 1'b1);
        chk("t2_data_wdata", bus_wdata, 32'h1234_5678);
        chk("t2_data_addr", bus_addr, 32'h8000_1000);
        cyc(); cyc();
        chk1("t2_inst_second_wr", bus_wr, 1'b0);
        chk("t2_inst_addr", bus_addr, 32'hBFC0_0004);
        cyc(); cyc();
        chk("t2_stall_cycles", nstall, 32'd4);
        chk("t2_inst_rdata", inst_rdata, 32'h8C09_0000);
        chk("t2_store_keeps_rdata", data_rdata, 32'd0);
        step(); inst_req = 1'b0; data_req = 1'b0; data_wr = 1'b0; sample();

        // Store completes under external stall
        nhs = 0;
        step();
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
        data_addr = 32'h8000_2000; data_wdata = 32'hCAFE_F00D; ext_stall = 1'b1;
        sample();
        repeat (4) cyc();
        chk1("t3_held_no_stall", cpu_stall, 1'b0);
        chk("t3_one_write", nhs, 32'd1);
        step(); ext_stall = 1'b0; sample();
        chk1("t3_done_still_held", cpu_stall, 1'b0);
        step(); data_addr = 32'h8000_2004; data_wdata = 32'h0000_0001; sample();
        chk1("t3_flags_cleared", cpu_stall, 1'b1);
        repeat (3) cyc();
        chk("t3_second_write", nhs, 32'd2);
        chk("t3_second_wdata", bus_wdata, 32'h0000_0001);
        chk1("t3_end_stall", cpu_stall, 1'b0);
        step(); data_req = 1'b0; data_wr = 1'b0; sample();

        // Slow slave, request inputs change mid-transaction
        s_addr_dly = 2; s_data_dly = 3;
        step();
        data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2;
        data_addr = 32'h8000_3000; data_wdata = 32'h55AA_1234;
        sample();
        nstall = 0;
        cyc();
        step(); data_addr = 32'h0; data_wdata = 32'h0; sample();
        chk("t4_addr_aphase", bus_addr, 32'h8000_3000);
        chk("t4_wdata_aphase", bus_wdata, 32'h55AA_1234);
        repeat (3) cyc();
        chk("t4_addr_dphase", bus_addr, 32'h8000_3000);
        chk1("t4_req_low_dphase", bus_req, 1'b0);
        repeat (3) cyc();
        chk("t4_stall_cycles", nstall, 32'd7);
        chk("t4_wdata_end", bus_wdata, 32'h55AA_1234);
        chk1("t4_end_stall", cpu_stall, 1'b0);
        step(); data_req = 1'b0; data_wr = 1'b0; sample();
        s_addr_dly = 0; s_data_dly = 0;

        // Half-word load
        s_rdata = 32'h1357_2468;
        step(); data_req = 1'b1; data_wr = 1'b0; data_size = 2'd1; data_addr = 32'h8000_4000; sample();
        cyc();
        chk("t5_bus_size_half", {30'd0, bus_size}, 32'd1);
        cyc(); cyc();
        chk("t5_load_rdata", data_rdata, 32'h1357_2468);
        step(); data_req = 1'b0; sample();

        // Reset during the data phase, then a stray data_ok in IDLE
        s_mute = 1'b1;
        step(); data_req = 1'b1; data_addr = 32'h8000_4010; sample();
        repeat (3) cyc();
        step(); rst = 1'b0; data_req = 1'b0; sample();
        s_late = 1'b1; s_mute = 1'b0; s_phase = 1'b0; s_cnt = 0;
        step(); rst = 1'b1; sample();
        chk1("t6_rst_stall", cpu_stall, 1'b0);
        chk1("t6_rst_bus_req", bus_req, 1'b0);
        chk("t6_rst_data_rdata", data_rdata, 32'd0);
        s_rdata = 32'h0BAD_F00D;
        step(); data_req = 1'b1; sample();
        chk1("t6_no_done_flag", cpu_stall, 1'b1);
        repeat (3) cyc();
        chk("t6_post_rst_load", data_rdata, 32'h0BAD_F00D);
        step(); data_req = 1'b0; sample();

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
        // Slave never acknowledges the data phase
        s_mute = 1'b1;
        step(); data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_addr = 32'h8000_5000; sample();
        repeat (9) cyc();
        chk1("t7_no_err_yet", bus_err, 1'b0);
        chk1("t7_waiting_stall", cpu_stall, 1'b1);
        cyc();
        chk1("t7_err_pulse", bus_err, 1'b1);
        chk("t7_fill_rdata", data_rdata, 32'hDEAD_BEEF);
        chk1("t7_done_stall", cpu_stall, 1'b0);
        step(); data_req = 1'b0; sample();
        chk1("t7_err_one_cycle", bus_err, 1'b0);
        chk1("t7_err_sticky", bus_err_sticky, 1'b1);
        s_mute = 1'b0; s_phase = 1'b0; s_cnt = 0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
